fp_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one floating-point adder datapath between two requesters. It accepts an operand pair from one requester at a time, issues a single start pulse to the adder, waits for completion with a watchdog, and returns the 32-bit result and 4-bit status to the requester that issued the operation. It sits between the requesting logic and the adder; operands use the adder's word format (bit 0 sign, bits 1:6 exponent, bits 7:31 mantissa) and pass through unchanged.

---
 rtl/fp_add_arbiter.sv | 108 ++++++++++
 tb/tb_fp_add_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one floating-point adder between two requesters.
// Issues one start pulse per accepted operand pair and guards the wait with a watchdog.
module fp_add_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_status,
    output logic        fpu_start,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        busy,
    output logic        timeout_flag
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t      state, state_next;
    logic        gid;
    logic        prio;
    logic [7:0]  count;
    logic        gnt0, gnt1;
    logic        limit_hit;

    assign gnt0      = req0_valid && (!req1_valid || !prio);
    assign gnt1      = req1_valid && (!req0_valid || prio);
    assign limit_hit = (count == LIMIT);

    assign fpu_start   = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign resp0_valid = (state == RESPOND) && !gid;
    assign resp1_valid = (state == RESPOND) && gid;

    // ready is gated by reset so it reads 0 while reset is held, even with valid high
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt0 && reset;
                req1_ready = gnt1 && reset;
                if (gnt0 || gnt1) state_next = ISSUE;
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (fpu_done || limit_hit) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gid          <= 1'b0;
            prio         <= 1'b0;
            count        <= '0;
            fpu_op_a     <= '0;
            fpu_op_b     <= '0;
            resp_data    <= '0;
            resp_status  <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        gid      <= gnt1;
                        fpu_op_a <= gnt1 ? req1_op_a : req0_op_a;
                        fpu_op_b <= gnt1 ? req1_op_b : req0_op_b;
                    end
                end
                ISSUE: count <= '0;
                WAIT: begin
                    count <= count + 8'd1;
                    // done takes precedence over the watchdog limit in the same cycle
                    if (fpu_done) begin
                        resp_data   <= fpu_data;
                        resp_status <= fpu_status;
                    end else if (limit_hit) begin
                        resp_data    <= '0;
                        resp_status  <= '0;
                        timeout_flag <= 1'b1;
                    end
                end
                RESPOND: prio <= ~gid;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: bench-owned adder model, handshake/response
// monitors, and per-scenario tasks comparing against expectations derived from the rules.
`timescale 1ns/1ps
module tb_fp_add_arbiter;

    localparam int TO   = 8;
    localparam int HALF = 5000;

    logic        clock_100kHz = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp_data;
    logic [3:0]  resp_status;
    logic        fpu_start;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_data = '0;
    logic [3:0]  fpu_status = '0;
    logic        busy, timeout_flag;

    fp_add_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock_100kHz(clock_100kHz), .reset(reset),
        .req0_valid(req0_valid), .req0_op_a(req0_op_a), .req0_op_b(req0_op_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op_a(req1_op_a), .req1_op_b(req1_op_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .resp_status(resp_status),
        .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_done(fpu_done), .fpu_data(fpu_data), .fpu_status(fpu_status),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    always #HALF clock_100kHz = ~clock_100kHz;

    typedef struct { int id; logic [31:0] a; logic [31:0] b; int edge_n; } acc_t;
    typedef struct { int id; logic [31:0] data; logic [3:0] status; int edge_n; } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_prio = 0;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    // adder model controls
    int          adder_delay = 3;   // 0 = never completes
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_data = '0;
    logic [3:0]  fixed_status = '0;
    bit          spur_pulse = 1'b0;

    function automatic logic [31:0] model_data(input logic [31:0] a, input logic [31:0] b);
        return use_fixed ? fixed_data : a + b;
    endfunction

    function automatic logic [3:0] model_status(input logic [31:0] a, input logic [31:0] b);
        logic [3:0] s;
        s = 4'b0001 << (a[1:0] ^ b[1:0]);
        return use_fixed ? fixed_status : s;
    endfunction

    always @(posedge clock_100kHz) cyc <= cyc + 1;

    // monitor: edge_n is the rising edge at which the sampled event completes
    always @(negedge clock_100kHz) begin
        if (reset) begin
            if (req0_valid && req0_ready) acc_q.push_back('{0, req0_op_a, req0_op_b, cyc + 1});
            if (req1_valid && req1_ready) acc_q.push_back('{1, req1_op_a, req1_op_b, cyc + 1});
            if (resp0_valid) rsp_q.push_back('{0, resp_data, resp_status, cyc + 1});
            if (resp1_valid) rsp_q.push_back('{1, resp_data, resp_status, cyc + 1});
        end
    end

    // adder model: done in the adder_delay-th cycle after the start cycle
    initial begin : adder
        int          ad_cnt;
        bit          ad_busy;
        logic [31:0] ad_a, ad_b;
        ad_cnt = 0; ad_busy = 1'b0; ad_a = '0; ad_b = '0;
        forever begin
            @(posedge clock_100kHz); #1;
            fpu_done = 1'b0;
            if (!reset) begin
                ad_busy = 1'b0;
            end else if (spur_pulse) begin
                fpu_done = 1'b1; fpu_data = $urandom; fpu_status = 4'b1000;
            end else if (ad_busy) begin
                ad_cnt++;
                if (ad_cnt == adder_delay) begin
                    fpu_done   = 1'b1;
                    fpu_data   = model_data(ad_a, ad_b);
                    fpu_status = model_status(ad_a, ad_b);
                    ad_busy    = 1'b0;
                end
            end
            if (reset && fpu_start) begin
                ad_busy = (adder_delay != 0); ad_cnt = 0; ad_a = fpu_op_a; ad_b = fpu_op_b;
            end
        end
    end

    task automatic drive_req(input int who, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clock_100kHz); #1;
        if (who == 0) begin req0_valid = 1'b1; req0_op_a = a; req0_op_b = b; end
        else          begin req1_valid = 1'b1; req1_op_a = a; req1_op_b = b; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock_100kHz);
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin ok = 1'b1; break; end
        end
        @(posedge clock_100kHz); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL handshake: requester %0d got ready=0, expected 1 within 50 cycles", who); end
    endtask

    task automatic wait_rsp(output bit got, output rsp_t r);
        got = 1'b0;
        r = '{0, '0, '0, 0};
        for (int i = 0; i < 400; i++) begin
            if (rsp_q.size() > 0) begin r = rsp_q.pop_front(); got = 1'b1; break; end
            @(posedge clock_100kHz); #1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL response_wait: got none, expected a response within 400 cycles"); end
    endtask

    task automatic run_op(input int who, input logic [31:0] a, input logic [31:0] b, input int k,
                          output rsp_t r, output acc_t ac);
        bit got;
        adder_delay = k;
        drive_req(who, a, b);
        ac = '{-1, '0, '0, 0};
        if (acc_q.size() > 0) ac = acc_q.pop_front();
        wait_rsp(got, r);
        if (got) exp_prio = 1 - r.id;
    endtask

    task automatic test_reset;
        logic [111:0] obs;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1000;
        obs = {req0_ready, req1_ready, resp0_valid, resp1_valid, fpu_start, busy, timeout_flag,
               resp_data, resp_status, fpu_op_a, fpu_op_b, 1'b0};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, expected 0", obs); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #(4*HALF + 1000);
        reset = 1'b1;
        exp_prio = 0;
    endtask

    task automatic test_single;
        rsp_t r; acc_t ac;
        use_fixed = 1'b1; fixed_data = 32'h1F400000; fixed_status = 4'b0001;
        run_op(0, 32'h1F000000, 32'h1E800000, 3, r, ac);
        use_fixed = 1'b0;
        checks++;
        if (r.id !== 0 || r.data !== 32'h1F400000 || r.status !== 4'b0001 || r.edge_n - ac.edge_n != 5) begin
            errors++;
            $display("FAIL single: id %0d data %h status %b lat %0d, expected id 0 data 1f400000 status 0001 lat 5",
                     r.id, r.data, r.status, r.edge_n - ac.edge_n);
        end
        repeat (4) @(posedge clock_100kHz);
        #1;
        checks++;
        if (rsp_q.size() != 0 || fpu_op_a !== 32'h1F000000 || fpu_op_b !== 32'h1E800000) begin
            errors++;
            $display("FAIL single_after: extra responses %0d op_a %h op_b %h, expected 0 1f000000 1e800000",
                     rsp_q.size(), fpu_op_a, fpu_op_b);
        end
    endtask

    task automatic test_random;
        rsp_t r; acc_t ac; int who; int k; logic [31:0] a, b;
        for (int n = 0; n < 6; n++) begin
            who = $urandom_range(0, 1); k = $urandom_range(1, TO - 1);
            a = $urandom; b = $urandom;
            run_op(who, a, b, k, r, ac);
            checks++;
            if (r.id != who || r.data !== a + b || r.status !== model_status(a, b) ||
                r.edge_n - ac.edge_n != k + 2 || timeout_flag !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d]: id %0d data %h status %b lat %0d tflag %b, expected id %0d data %h status %b lat %0d tflag 0",
                         n, r.id, r.data, r.status, r.edge_n - ac.edge_n, timeout_flag,
                         who, a + b, model_status(a, b), k + 2);
            end
        end
    endtask

    task automatic test_race;
        rsp_t r; acc_t ac; logic [31:0] a, b;
        a = $urandom; b = $urandom;
        run_op(1, a, b, TO, r, ac);
        #1;
        checks++;
        if (r.id != 1 || r.data !== a + b || r.status !== model_status(a, b) ||
            r.edge_n - ac.edge_n != TO + 2 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL race: id %0d data %h status %b lat %0d tflag %b, expected id 1 data %h status %b lat %0d tflag 0",
                     r.id, r.data, r.status, r.edge_n - ac.edge_n, timeout_flag, a + b, model_status(a, b), TO + 2);
        end
    endtask

    task automatic test_contention;
        int n; int first; int d; int want; bit acc0, acc1, got; rsp_t r; acc_t ac;
        acc_q.delete(); rsp_q.delete();
        d = $urandom_range(1, 4); adder_delay = d; first = exp_prio; n = 0;
        @(posedge clock_100kHz); #1;
        req0_valid = 1'b1; req0_op_a = $urandom; req0_op_b = $urandom;
        req1_valid = 1'b1; req1_op_a = $urandom; req1_op_b = $urandom;
        for (int i = 0; i < 300 && n < 4; i++) begin
            @(negedge clock_100kHz);
            acc0 = req0_valid && req0_ready; acc1 = req1_valid && req1_ready;
            @(posedge clock_100kHz); #1;
            if (acc0) begin n++; req0_op_a = $urandom; req0_op_b = $urandom; end
            if (acc1) begin n++; req1_op_a = $urandom; req1_op_b = $urandom; end
            if (n >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL contention_accepts: got %0d, expected 4", n); end
        for (int j = 0; j < 4; j++) begin
            want = (first + j) % 2;
            wait_rsp(got, r);
            ac = '{-1, '0, '0, 0};
            if (acc_q.size() > 0) ac = acc_q.pop_front();
            if (got) exp_prio = 1 - r.id;
            checks++;
            if (ac.id != want || r.id != want || r.data !== ac.a + ac.b ||
                r.status !== model_status(ac.a, ac.b) || r.edge_n - ac.edge_n != d + 2) begin
                errors++;
                $display("FAIL contention[%0d]: grant %0d resp %0d data %h status %b lat %0d, expected grant/resp %0d data %h status %b lat %0d",
                         j, ac.id, r.id, r.data, r.status, r.edge_n - ac.edge_n,
                         want, ac.a + ac.b, model_status(ac.a, ac.b), d + 2);
            end
        end
    endtask

    task automatic test_spurious;
        int busy_seen; rsp_t r; acc_t ac; logic [31:0] a, b;
        busy_seen = 0;
        rsp_q.delete();
        @(posedge clock_100kHz); #2;
        spur_pulse = 1'b1;
        @(posedge clock_100kHz); #2;
        spur_pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_100kHz);
            if (busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL spurious_idle: busy cycles %0d responses %0d, expected 0 0", busy_seen, rsp_q.size());
        end
        a = $urandom; b = $urandom;
        run_op(0, a, b, 2, r, ac);
        checks++;
        if (r.id != 0 || r.data !== a + b || r.edge_n - ac.edge_n != 4) begin
            errors++;
            $display("FAIL spurious_next: id %0d data %h lat %0d, expected id 0 data %h lat 4",
                     r.id, r.data, r.edge_n - ac.edge_n, a + b);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [111:0] obs; bit busy_before; bit got; rsp_t r; acc_t ac; logic [31:0] a0, b0;
        adder_delay = 0;
        drive_req(1, $urandom, $urandom);
        repeat (2) @(posedge clock_100kHz);
        #3;
        busy_before = busy;
        reset = 1'b0;
        #1;
        obs = {req0_ready, req1_ready, resp0_valid, resp1_valid, fpu_start, busy, timeout_flag,
               resp_data, resp_status, fpu_op_a, fpu_op_b, ~busy_before};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_wait: got %h, expected 0", obs); end
        @(posedge clock_100kHz); #HALF;
        reset = 1'b1;
        exp_prio = 0;
        acc_q.delete();
        repeat (15) @(posedge clock_100kHz);
        #1;
        checks++;
        if (rsp_q.size() != 0) begin
            errors++; $display("FAIL reset_no_resp: got %0d responses, expected 0", rsp_q.size());
        end
        adder_delay = 2;
        a0 = $urandom; b0 = $urandom;
        req0_valid = 1'b1; req0_op_a = a0; req0_op_b = b0;
        req1_valid = 1'b1; req1_op_a = $urandom; req1_op_b = $urandom;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) begin
            @(posedge clock_100kHz); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        ac = '{-1, '0, '0, 0};
        if (acc_q.size() > 0) ac = acc_q.pop_front();
        wait_rsp(got, r);
        if (got) exp_prio = 1 - r.id;
        checks++;
        if (ac.id != exp_prio_reset_grant() || r.id != 0 || r.data !== a0 + b0) begin
            errors++;
            $display("FAIL reset_next: grant %0d resp %0d data %h, expected grant 0 resp 0 data %h",
                     ac.id, r.id, r.data, a0 + b0);
        end
    endtask

    function automatic int exp_prio_reset_grant();
        return 0;
    endfunction

    task automatic test_timeout;
        rsp_t r; acc_t ac; logic [31:0] a, b; bit flag_before;
        flag_before = timeout_flag;
        run_op(1, $urandom, $urandom, 0, r, ac);
        #1;
        checks++;
        if (flag_before !== 1'b0 || r.id != 1 || r.data !== 32'h0 || r.status !== 4'b0000 ||
            r.edge_n - ac.edge_n != TO + 2 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout: flag_before %b id %0d data %h status %b lat %0d tflag %b, expected 0 1 00000000 0000 %0d 1",
                     flag_before, r.id, r.data, r.status, r.edge_n - ac.edge_n, timeout_flag, TO + 2);
        end
        for (int n = 0; n < 2; n++) begin
            a = $urandom; b = $urandom;
            run_op(n, a, b, 2, r, ac);
            #1;
            checks++;
            if (r.id != n || r.data !== a + b || r.status !== model_status(a, b) || timeout_flag !== 1'b1) begin
                errors++;
                $display("FAIL timeout_sticky[%0d]: id %0d data %h status %b tflag %b, expected id %0d data %h status %b tflag 1",
                         n, r.id, r.data, r.status, timeout_flag, n, a + b, model_status(a, b));
            end
        end
    endtask

    initial begin
        #(2 * HALF * 20000);
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        test_reset();
        test_single();
        test_random();
        test_race();
        test_contention();
        test_spurious();
        test_reset_mid_wait();
        test_timeout();
        repeat (3) @(posedge clock_100kHz);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
